// File: rtl/fir_coeff_pkg.sv
// fir_coeff_pkg: sizes, default 5x5 kernel and FSM encoding shared by the coefficient controller
package fir_coeff_pkg;
    localparam int NUM_TAPS = 25;
    localparam int COEFF_W  = 16;
    localparam int ADDR_W   = 4;
    localparam int WORDS    = 13;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);
    // listed from tap 24 down to tap 0
    localparam logic [NUM_TAPS*COEFF_W-1:0] DEFAULT_KERNEL = {
        16'h0000, 16'h0000, 16'hFF00, 16'h0000, 16'h0000,
        16'h0000, 16'hFF00, 16'hFE00, 16'hFF00, 16'h0000,
        16'hFF00, 16'hFE00, 16'h1000, 16'hFE00, 16'hFF00,
        16'h0000, 16'hFF00, 16'hFE00, 16'hFF00, 16'h0000,
        16'h0000, 16'h0000, 16'hFF00, 16'h0000, 16'h0000
    };
    typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} state_t;
endpackage

// File: rtl/fir_coeff_bank.sv
// fir_coeff_bank: shadow and active coefficient registers with word write and whole-bank copy
module fir_coeff_bank
    import fir_coeff_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [31:0]                  wr_data,
    input  logic                         copy_en,
    output logic [NUM_TAPS*COEFF_W-1:0]  active_o
);
    logic [NUM_TAPS*COEFF_W-1:0] shadow;
    always_ff @(posedge clk) begin
        if (!rst) begin
            shadow   <= DEFAULT_KERNEL;
            active_o <= DEFAULT_KERNEL;
        end else begin
            if (wr_en) begin
                shadow[int'(wr_addr)*2*COEFF_W +: COEFF_W] <= wr_data[15:0];
                // the last word holds only tap 24; its upper half has no tap
                if (wr_addr != LAST_ADDR)
                    shadow[(int'(wr_addr)*2+1)*COEFF_W +: COEFF_W] <= wr_data[31:16];
            end
            if (copy_en)
                active_o <= shadow;
        end
    end
endmodule

// File: rtl/fir_coeff_ctrl.sv
// fir_coeff_ctrl: frame-synchronous coefficient commit for the 5x5 FIR.
// Define FIR_COEFF_READBACK_EN to add the registered rd_addr/rd_data readback of the active bank.
module fir_coeff_ctrl
    import fir_coeff_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         vs_i,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [31:0]                  wr_data,
    output logic                         wr_ready,
    input  logic                         commit_req,
    output logic [NUM_TAPS*COEFF_W-1:0]  coeff_o,
    output logic                         pending_o,
    output logic                         commit_done_o,
    output logic                         err_o
`ifdef FIR_COEFF_READBACK_EN
    ,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic [31:0]                  rd_data
`endif
);
    state_t state, state_n;
    logic vs_q, vs_rise, wr_fire, wr_ok, wr_bad, apply;
    assign vs_rise  = vs_i & ~vs_q;
    assign wr_ready = state == IDLE;
    assign pending_o = state == ARMED;
    assign wr_fire  = wr_en & wr_ready;
    assign wr_ok    = wr_fire & (wr_addr <= LAST_ADDR);
    assign wr_bad   = wr_fire & (wr_addr > LAST_ADDR);
    assign apply    = (state == ARMED) & vs_rise;
    always_comb begin
        state_n = state;
        if (state == IDLE)
            state_n = commit_req ? ARMED : IDLE;
        else
            state_n = vs_rise ? IDLE : ARMED;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            vs_q          <= 1'b0;
            commit_done_o <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            state         <= state_n;
            vs_q          <= vs_i;
            commit_done_o <= apply;
            err_o         <= apply ? 1'b0 : (err_o | wr_bad);
        end
    end
    fir_coeff_bank u_bank (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_ok),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .copy_en  (apply),
        .active_o (coeff_o)
    );
`ifdef FIR_COEFF_READBACK_EN
    logic [COEFF_W-1:0] rd_lo, rd_hi;
    // out-of-range selects are never used: the mux below masks them
    assign rd_lo = coeff_o[int'(rd_addr)*2*COEFF_W +: COEFF_W];
    assign rd_hi = coeff_o[(int'(rd_addr)*2+1)*COEFF_W +: COEFF_W];
    always_ff @(posedge clk) begin
        if (!rst)
            rd_data <= '0;
        else
            rd_data <= (rd_addr < LAST_ADDR) ? {rd_hi, rd_lo} :
                       (rd_addr == LAST_ADDR) ? {16'h0000, rd_lo} : 32'h0;
    end
`endif
endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// tb_fir_coeff_ctrl: directed vector table plus hand sequences for the coefficient controller
module tb_fir_coeff_ctrl;
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          vs_i = 1'b0;
    logic          wr_en = 1'b0;
    logic [3:0]    wr_addr = '0;
    logic [31:0]   wr_data = '0;
    logic          commit_req = 1'b0;
    logic          wr_ready, pending_o, commit_done_o, err_o;
    logic [399:0]  coeff_o;
`ifdef FIR_COEFF_READBACK_EN
    logic [3:0]    rd_addr = 4'd1;
    logic [31:0]   rd_data;
`endif
    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    fir_coeff_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .vs_i          (vs_i),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .commit_req    (commit_req),
        .coeff_o       (coeff_o),
        .pending_o     (pending_o),
        .commit_done_o (commit_done_o),
        .err_o         (err_o)
`ifdef FIR_COEFF_READBACK_EN
        ,
        .rd_addr       (rd_addr),
        .rd_data       (rd_data)
`endif
    );

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] data;
        logic        cr;
        logic        vs;
        logic        rdy;
        logic        pend;
        logic        done;
        logic        err;
        int          tap;
        logic [15:0] tapv;
    } vec_t;

    vec_t vecs[18];

    function automatic logic [15:0] tap(input int k);
        return coeff_o[k*16 +: 16];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cyc(input logic we, input logic [3:0] a, input logic [31:0] d,
                       input logic cr, input logic vs);
        wr_en = we; wr_addr = a; wr_data = d; commit_req = cr; vs_i = vs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int dones;
        //          we    addr   data           cr    vs    rdy   pend  done  err  tap  tapv
        vecs[0]  = '{1'b0, 4'd0,  32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12, 16'h1000};
        vecs[1]  = '{1'b0, 4'd0,  32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2,  16'hFF00};
        vecs[2]  = '{1'b0, 4'd0,  32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0,  16'h0000};
        vecs[3]  = '{1'b1, 4'd6,  32'h0200_0400, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12, 16'h1000};
        vecs[4]  = '{1'b0, 4'd0,  32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12, 16'h1000};
        vecs[5]  = '{1'b1, 4'd0,  32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0,  16'h0000};
        vecs[6]  = '{1'b1, 4'd15, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 13, 16'hFE00};
        vecs[7]  = '{1'b0, 4'd0,  32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 12, 16'h0400};
        vecs[8]  = '{1'b0, 4'd0,  32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 13, 16'h0200};
        vecs[9]  = '{1'b0, 4'd0,  32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1,  16'h0000};
        vecs[10] = '{1'b1, 4'd14, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 24, 16'h0000};
        vecs[11] = '{1'b0, 4'd0,  32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0,  16'h0000};
        vecs[12] = '{1'b1, 4'd12, 32'hABCD_7777, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 24, 16'h0000};
        vecs[13] = '{1'b0, 4'd0,  32'h0,         1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 24, 16'h0000};
        vecs[14] = '{1'b0, 4'd0,  32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 24, 16'h0000};
        vecs[15] = '{1'b0, 4'd0,  32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12, 16'h0400};
        vecs[16] = '{1'b0, 4'd0,  32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 24, 16'h7777};
        vecs[17] = '{1'b0, 4'd0,  32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 22, 16'hFF00};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("reset_wr_ready", 32'(wr_ready), 32'd1);
        chk("reset_err", 32'(err_o), 32'd0);
        chk("reset_pending", 32'(pending_o), 32'd0);
        chk("reset_kernel", coeff_o[31:0], 32'h0000_0000);
`ifdef FIR_COEFF_READBACK_EN
        chk("readback_addr1", rd_data, 32'h0000_FF00);
`endif

        for (int i = 0; i < 18; i++) begin
            cyc(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].cr, vecs[i].vs);
            chk($sformatf("v%0d_wr_ready", i), 32'(wr_ready), 32'(vecs[i].rdy));
            chk($sformatf("v%0d_pending", i), 32'(pending_o), 32'(vecs[i].pend));
            chk($sformatf("v%0d_done", i), 32'(commit_done_o), 32'(vecs[i].done));
            chk($sformatf("v%0d_err", i), 32'(err_o), 32'(vecs[i].err));
            chk($sformatf("v%0d_tap%0d", i, vecs[i].tap), 32'(tap(vecs[i].tap)), 32'(vecs[i].tapv));
        end

        // vs_i held high for 100 cycles applies exactly once
        cyc(1'b1, 4'd0, 32'h0003_0005, 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 32'h0, 1'b1, 1'b0);
        dones = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1'b0, 4'd0, 32'h0, 1'b0, 1'b1);
            dones += int'(commit_done_o);
        end
        chk("vs_hold_single_apply", 32'(dones), 32'd1);
        chk("vs_hold_tap0", 32'(tap(0)), 32'h0005);
        chk("vs_hold_tap1", 32'(tap(1)), 32'h0003);

        // reset while armed discards the commit and restores defaults
        cyc(1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 4'd6, 32'h1111_2222, 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 32'h0, 1'b1, 1'b0);
        chk("rst_armed_pending_before", 32'(pending_o), 32'd1);
        rst = 1'b0;
        cyc(1'b0, 4'd0, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        chk("rst_armed_pending", 32'(pending_o), 32'd0);
        chk("rst_armed_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_armed_tap12", 32'(tap(12)), 32'h1000);
        chk("rst_armed_tap0", 32'(tap(0)), 32'h0000);
        chk("rst_armed_kernel", 32'(coeff_o == fir_coeff_pkg::DEFAULT_KERNEL), 32'd1);
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 4'd0, 32'h0, 1'b0, i >= 1);
            dones += int'(commit_done_o);
        end
        chk("rst_armed_no_done", 32'(dones), 32'd0);
        chk("rst_armed_tap12_after_vs", 32'(tap(12)), 32'h1000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
